spam_timer: RTL and testbench
=============================

# spam_timer

Memory-mapped programmable timer on the SPAM peripheral bus, sitting downstream of the core's SPAM master port as a sibling of the console I/O device. It decodes SPAM requests addressed to its device ID, exposes a prescaled 32-bit counter with compare/auto-reload, and returns read data and a completion strobe whose outputs are OR-merged into the core's `spami_*` inputs. A match raises a sticky status bit and, optionally, a level interrupt to the core.

## Interface
- `TMR_DID`, 1: SPAM device ID this block answers to.
- `PRESCALE_W`, 8: width of the prescaler divider field and counter.
- `clk` in 1: core clock; all logic on its rising edge.
- `rst` in 1: reset; one clock, asynchronous, active-high.
- `spamo_valid` in 1: one-cycle request strobe from the core.
- `spamo_r_nw` in 1: 1 = read, 0 = write.
- `spamo_did` in SPAM_DID_HI+1: target device ID.
- `spamo_addr` in SPAM_ADDR_HI+1: register offset; bits [3:2] select the register, other bits ignored.
- `spamo_data` in SPAM_DATA_HI+1 (32): write data.
- `tmr__spami_busy_b` out 1: one-cycle completion strobe for an owned access; 0 otherwise.
- `tmr__spami_data` out SPAM_DATA_HI+1: read data during the completion strobe; 0 otherwise, so it can be OR-merged.
- `tmr__irq` out 1: level interrupt, `STATUS.match & CTRL.ie`.

## Operation
- Registers, selected by addr[3:2]:
  - 0 `COUNT`: read/write counter.
  - 1 `COMPARE`: read/write compare value.
  - 2 `CTRL`: bit0 `en`, bit1 `reload`, bit2 `ie`, bits[8+PRESCALE_W-1:8] `div`; other bits read 0.
  - 3 `STATUS`: bit0 `match`; writing 1 clears it, writing 0 has no effect.
- Request decode: an access is owned when `spamo_valid & (spamo_did == TMR_DID)`. Requests that are not owned are ignored entirely, with no response.
- Prescaler:
  - When `en`=1, the prescaler counts 0..`div` and then wraps.
  - On wrap, a tick occurs and COUNT increments by 1 (mod 2^32).
  - `div`=0 gives a tick every cycle.
  - When `en`=0, both the prescaler and COUNT hold.
- Match: on a tick where the next COUNT value equals COMPARE, `match` is set.
  - With `reload`=1, COUNT loads 0 instead of COMPARE.
  - With `reload`=0, COUNT keeps counting and wraps through 2^32.
- Simultaneous events:
  - A software write to COUNT in the same cycle as a tick: the write wins and the tick is dropped.
  - A write-1-clear of STATUS in the same cycle as a new match: the set wins.
  - A write to CTRL resets the prescaler to 0.
- Reset values: COUNT=0, COMPARE=0xFFFFFFFF, CTRL=0, STATUS=0, prescaler=0, `tmr__spami_busy_b`=0, `tmr__spami_data`=0, `tmr__irq`=0.
- Reset mid-access: any pending response is dropped and no strobe is issued.

## Timing
- Owned request accepted in cycle N → `tmr__spami_busy_b`=1 for exactly cycle N+1, with read data registered and valid in N+1. Writes also strobe in N+1, with data 0.
- Writes take effect at the end of cycle N, so a read in cycle N+1 returns the new value.
- Read data is the register value sampled at the end of cycle N.
- The block is fully pipelined: back-to-back owned requests in N and N+1 produce strobes in N+1 and N+2. No stall is ever asserted.
- `tmr__irq` is registered and asserts in the cycle after `match` is set or `ie` is written to 1.

## Configuration
- `SPAM_TIMER_IRQ_EN`:
  - Defined: `CTRL.ie` is implemented and `tmr__irq` is driven as specified.
  - Undefined: `CTRL.ie` reads 0 and ignores writes; `tmr__irq` is tied to 0. The STATUS/match logic is unchanged.

## Test plan
- Reset, then read all four registers → data 0, 0xFFFFFFFF, 0, 0, each with a single-cycle strobe one cycle after its request.
- Write COMPARE=5, then CTRL=0x7 (div=0) → `match` sets 5 cycles after the CTRL write. COUNT reloads to 0. `tmr__irq`=1 one cycle later.
- CTRL div=3, en=1 → COUNT increments once every 4 cycles. Reading COUNT 40 cycles later returns 10 (±1 depending on the sample edge, checked by a bench model).
- Request with `spamo_did`≠TMR_DID → `tmr__spami_busy_b` and `tmr__spami_data` stay 0; register state unchanged.
- Write STATUS=1 in the same cycle as a match → `match` remains 1. A subsequent clear with no match → `match`=0 and `tmr__irq` drops next cycle.
- Assert `rst` for one cycle mid-count with a request pending → no strobe is issued, all registers return to reset values, and `tmr__irq`=0 immediately.

Source files
------------

// File: rtl/spam_timer.sv
// Prescaled 32-bit SPAM-bus timer with compare, auto-reload and sticky match status.
// Define SPAM_TIMER_IRQ_EN to implement CTRL.ie and drive tmr__irq; otherwise both read/tie to 0.
module spam_timer #(
  parameter int unsigned TMR_DID      = 1,
  parameter int unsigned PRESCALE_W   = 8,
  parameter int unsigned SPAM_DID_HI  = 3,
  parameter int unsigned SPAM_ADDR_HI = 15,
  parameter int unsigned SPAM_DATA_HI = 31
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    spamo_valid,
  input  logic                    spamo_r_nw,
  input  logic [SPAM_DID_HI:0]    spamo_did,
  input  logic [SPAM_ADDR_HI:0]   spamo_addr,
  input  logic [SPAM_DATA_HI:0]   spamo_data,
  output logic                    tmr__spami_busy_b,
  output logic [SPAM_DATA_HI:0]   tmr__spami_data,
  output logic                    tmr__irq
);

  localparam int unsigned DID_W  = SPAM_DID_HI + 1;
  localparam int unsigned DATA_W = SPAM_DATA_HI + 1;

  localparam logic [1:0] REG_COUNT   = 2'd0;
  localparam logic [1:0] REG_COMPARE = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  logic [31:0]           count_q;
  logic [31:0]           compare_q;
  logic                  en_q;
  logic                  reload_q;
  logic                  ie_q;
  logic [PRESCALE_W-1:0] div_q;
  logic [PRESCALE_W-1:0] pre_q;
  logic                  match_q;

  logic                  owned;
  logic                  rd_req;
  logic [1:0]            sel;
  logic [31:0]           wdata;
  logic                  wr_count;
  logic                  wr_compare;
  logic                  wr_ctrl;
  logic                  wr_status;
  logic                  tick;
  logic [31:0]           count_inc;
  logic                  hit;
  logic [31:0]           ctrl_rd;
  logic [31:0]           rd_mux;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{spamo_addr[SPAM_ADDR_HI:4], spamo_addr[1:0]};

  // Request decode, prescaler tick and match detection.
  always_comb begin
    owned      = spamo_valid && (spamo_did == DID_W'(TMR_DID));
    rd_req     = owned && spamo_r_nw;
    sel        = spamo_addr[3:2];
    wdata      = 32'(spamo_data);
    wr_count   = owned && !spamo_r_nw && (sel == REG_COUNT);
    wr_compare = owned && !spamo_r_nw && (sel == REG_COMPARE);
    wr_ctrl    = owned && !spamo_r_nw && (sel == REG_CTRL);
    wr_status  = owned && !spamo_r_nw && (sel == REG_STATUS);
    tick       = en_q && (pre_q == div_q);
    count_inc  = count_q + 32'd1;
    // A software COUNT write swallows a coincident tick, including its match.
    hit        = tick && !wr_count && (count_inc == compare_q);
  end

  // Register read mux; unimplemented bits read 0.
  always_comb begin
    ctrl_rd                  = '0;
    ctrl_rd[0]               = en_q;
    ctrl_rd[1]               = reload_q;
    ctrl_rd[2]               = ie_q;
    ctrl_rd[8 +: PRESCALE_W] = div_q;
    rd_mux                   = '0;
    case (sel)
      REG_COUNT:   rd_mux = count_q;
      REG_COMPARE: rd_mux = compare_q;
      REG_CTRL:    rd_mux = ctrl_rd;
      REG_STATUS:  rd_mux = {31'd0, match_q};
      default:     rd_mux = '0;
    endcase
  end

`ifdef SPAM_TIMER_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie_q     <= 1'b0;
      tmr__irq <= 1'b0;
    end else begin
      if (wr_ctrl) ie_q <= wdata[2];
      tmr__irq <= match_q && ie_q;
    end
  end
`else
  assign ie_q = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmr__irq <= 1'b0;
    else     tmr__irq <= 1'b0;
  end
`endif

  // Timer state and control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'hFFFF_FFFF;
      en_q      <= 1'b0;
      reload_q  <= 1'b0;
      div_q     <= '0;
      pre_q     <= '0;
      match_q   <= 1'b0;
    end else begin
      if (wr_ctrl)   pre_q <= '0;
      else if (tick) pre_q <= '0;
      else if (en_q) pre_q <= pre_q + PRESCALE_W'(1);

      if (wr_count)  count_q <= wdata;
      else if (tick) count_q <= (hit && reload_q) ? 32'd0 : count_inc;

      if (wr_compare) compare_q <= wdata;

      if (wr_ctrl) begin
        en_q     <= wdata[0];
        reload_q <= wdata[1];
        div_q    <= wdata[8 +: PRESCALE_W];
      end

      // Set has priority over a coincident write-1-clear.
      if (hit)                        match_q <= 1'b1;
      else if (wr_status && wdata[0]) match_q <= 1'b0;
    end
  end

  // Single-cycle completion strobe; data is zero unless returning a read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr__spami_busy_b <= 1'b0;
      tmr__spami_data   <= '0;
    end else begin
      tmr__spami_busy_b <= owned;
      tmr__spami_data   <= rd_req ? DATA_W'(rd_mux) : '0;
    end
  end

endmodule

// File: tb/tb_spam_timer.sv
// Directed self-checking bench for spam_timer; IRQ expectations follow SPAM_TIMER_IRQ_EN.
module tb_spam_timer;

  localparam logic [3:0] DID = 4'd1;
`ifdef SPAM_TIMER_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        r_nw = 1'b0;
  logic [3:0]  did = '0;
  logic [15:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int passed = 0;

  spam_timer dut (
    .clk               (clk),
    .rst               (rst),
    .spamo_valid       (valid),
    .spamo_r_nw        (r_nw),
    .spamo_did         (did),
    .spamo_addr        (addr),
    .spamo_data        (wdata),
    .tmr__spami_busy_b (busy),
    .tmr__spami_data   (rdata),
    .tmr__irq          (irq)
  );

  always #5 clk = ~clk;

  // Present one request (or idle) at a falling edge; returns at the next falling edge.
  task automatic step(input logic v, input logic rnw, input logic [3:0] d_id,
                      input logic [1:0] sel, input logic [31:0] d);
    valid = v;
    r_nw  = rnw;
    did   = d_id;
    addr  = {12'($urandom), sel, 2'($urandom)};
    wdata = d;
    @(negedge clk);
    valid = 1'b0;
    r_nw  = 1'b0;
    did   = '0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 4'd0, 2'd0, 32'd0);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] d);
    step(1'b1, 1'b0, DID, sel, d);
  endtask

  task automatic rd(input logic [1:0] sel);
    step(1'b1, 1'b1, DID, sel, 32'd0);
  endtask

  task automatic test_reset();
    logic [31:0] exp_rst [4];
    exp_rst = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rdata !== 32'h0 || irq !== 1'b0)
      $display("FAIL reset_outputs: busy=%0b data=%08h irq=%0b want 0/00000000/0", busy, rdata, irq);
    else passed++;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(2'(i));
      checks++;
      if (busy !== 1'b1 || rdata !== exp_rst[i])
        $display("FAIL reset_read_%0d: busy=%0b data=%08h want 1/%08h", i, busy, rdata, exp_rst[i]);
      else passed++;
      idle(1);
      checks++;
      if (busy !== 1'b0 || rdata !== 32'h0)
        $display("FAIL strobe_single_%0d: busy=%0b data=%08h want 0/00000000", i, busy, rdata);
      else passed++;
    end
  endtask

  task automatic test_match();
    wr(2'd1, 32'd5);
    checks++;
    if (busy !== 1'b1 || rdata !== 32'h0)
      $display("FAIL write_strobe: busy=%0b data=%08h want 1/00000000", busy, rdata);
    else passed++;
    wr(2'd2, 32'h7);
    idle(4);
    rd(2'd3);
    checks++;
    if (busy !== 1'b1 || rdata !== 32'h0 || irq !== 1'b0)
      $display("FAIL match_before: busy=%0b data=%08h irq=%0b want 1/00000000/0", busy, rdata, irq);
    else passed++;
    rd(2'd0);
    checks++;
    if (busy !== 1'b1 || rdata !== 32'h0 || irq !== IRQ_ON)
      $display("FAIL match_reload: busy=%0b count=%08h irq=%0b want 1/00000000/%0b", busy, rdata, irq, IRQ_ON);
    else passed++;
    rd(2'd3);
    checks++;
    if (busy !== 1'b1 || rdata !== 32'h1)
      $display("FAIL match_set: busy=%0b data=%08h want 1/00000001", busy, rdata);
    else passed++;
  endtask

  task automatic test_status_collision();
    wr(2'd2, 32'h0);
    wr(2'd0, 32'h0);
    wr(2'd3, 32'h1);
    wr(2'd1, 32'd3);
    wr(2'd2, 32'h7);
    idle(2);
    wr(2'd3, 32'h1);
    rd(2'd3);
    checks++;
    if (rdata !== 32'h1 || irq !== IRQ_ON)
      $display("FAIL clear_vs_set: data=%08h irq=%0b want 00000001/%0b", rdata, irq, IRQ_ON);
    else passed++;
    wr(2'd2, 32'h4);
    wr(2'd3, 32'h1);
    checks++;
    if (irq !== IRQ_ON)
      $display("FAIL irq_hold: irq=%0b want %0b", irq, IRQ_ON);
    else passed++;
    idle(1);
    checks++;
    if (irq !== 1'b0)
      $display("FAIL irq_drop: irq=%0b want 0", irq);
    else passed++;
    rd(2'd3);
    checks++;
    if (rdata !== 32'h0)
      $display("FAIL status_cleared: data=%08h want 00000000", rdata);
    else passed++;
    rd(2'd2);
    checks++;
    if (rdata !== (IRQ_ON ? 32'h4 : 32'h0))
      $display("FAIL ctrl_ie: data=%08h want %08h", rdata, IRQ_ON ? 32'h4 : 32'h0);
    else passed++;
  endtask

  task automatic test_prescale();
    wr(2'd2, 32'h0);
    wr(2'd0, 32'h0);
    wr(2'd3, 32'h1);
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd2, 32'h301);
    idle(40);
    rd(2'd0);
    checks++;
    if (rdata !== 32'd10)
      $display("FAIL prescale_40: count=%0d want 10", rdata);
    else passed++;
    rd(2'd0);
    checks++;
    if (busy !== 1'b1 || rdata !== 32'd10)
      $display("FAIL prescale_41: busy=%0b count=%0d want 1/10", busy, rdata);
    else passed++;
    idle(1);
    wr(2'd0, 32'd100);
    rd(2'd0);
    checks++;
    if (rdata !== 32'd100)
      $display("FAIL write_beats_tick: count=%0d want 100", rdata);
    else passed++;
    idle(3);
    rd(2'd0);
    checks++;
    if (rdata !== 32'd101)
      $display("FAIL tick_after_write: count=%0d want 101", rdata);
    else passed++;
    rd(2'd3);
    checks++;
    if (rdata !== 32'h0)
      $display("FAIL no_match: data=%08h want 00000000", rdata);
    else passed++;
  endtask

  task automatic test_not_owned();
    wr(2'd2, 32'h0);
    wr(2'd0, 32'h55);
    wr(2'd1, 32'hABCD);
    step(1'b1, 1'b0, 4'd2, 2'd0, 32'h99);
    checks++;
    if (busy !== 1'b0 || rdata !== 32'h0)
      $display("FAIL foreign_write: busy=%0b data=%08h want 0/00000000", busy, rdata);
    else passed++;
    step(1'b1, 1'b1, 4'd0, 2'd1, 32'h0);
    checks++;
    if (busy !== 1'b0 || rdata !== 32'h0)
      $display("FAIL foreign_read: busy=%0b data=%08h want 0/00000000", busy, rdata);
    else passed++;
    step(1'b1, 1'b0, 4'd3, 2'd2, 32'h1);
    step(1'b0, 1'b1, DID, 2'd1, 32'h0);
    checks++;
    if (busy !== 1'b0 || rdata !== 32'h0)
      $display("FAIL invalid_own_did: busy=%0b data=%08h want 0/00000000", busy, rdata);
    else passed++;
    rd(2'd0);
    checks++;
    if (rdata !== 32'h55)
      $display("FAIL foreign_count: count=%08h want 00000055", rdata);
    else passed++;
    rd(2'd1);
    checks++;
    if (rdata !== 32'hABCD)
      $display("FAIL foreign_compare: data=%08h want 0000abcd", rdata);
    else passed++;
    rd(2'd2);
    checks++;
    if (rdata !== 32'h0)
      $display("FAIL foreign_ctrl: data=%08h want 00000000", rdata);
    else passed++;
    wr(2'd2, 32'hFFFF_FFF8);
    rd(2'd2);
    checks++;
    if (rdata !== 32'h0000_FF00)
      $display("FAIL ctrl_reserved: data=%08h want 0000ff00", rdata);
    else passed++;
    wr(2'd2, 32'h0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_rst [4];
    exp_rst = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
    wr(2'd0, 32'h0);
    wr(2'd1, 32'd2);
    wr(2'd2, 32'h7);
    idle(4);
    checks++;
    if (irq !== IRQ_ON)
      $display("FAIL irq_before_reset: irq=%0b want %0b", irq, IRQ_ON);
    else passed++;
    valid = 1'b1;
    r_nw  = 1'b1;
    did   = DID;
    addr  = 16'h0000;
    rst   = 1'b1;
    #1;
    checks++;
    if (irq !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_async: irq=%0b busy=%0b want 0/0", irq, busy);
    else passed++;
    @(negedge clk);
    rst   = 1'b0;
    valid = 1'b0;
    r_nw  = 1'b0;
    did   = '0;
    checks++;
    if (busy !== 1'b0 || rdata !== 32'h0)
      $display("FAIL reset_drops_req: busy=%0b data=%08h want 0/00000000", busy, rdata);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      rd(2'(i));
      checks++;
      if (busy !== 1'b1 || rdata !== exp_rst[i])
        $display("FAIL post_reset_%0d: busy=%0b data=%08h want 1/%08h", i, busy, rdata, exp_rst[i]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_status_collision();
    test_prescale();
    test_not_owned();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
